// File: rtl/cam_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cam_pkg                                                                    |
// | Frame geometry, capture FSM encoding and RGB565 field layout.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package cam_pkg;

   localparam int H_ACTIVE     = 640;
   localparam int V_ACTIVE     = 480;
   localparam int FRAME_PIXELS = H_ACTIVE * V_ACTIVE;

   typedef logic [1:0] cam_state_t;
   localparam cam_state_t IDLE       = 2'd0;
   localparam cam_state_t WAIT_FRAME = 2'd1;
   localparam cam_state_t ACTIVE     = 2'd2;

   // Bit positions inside the 16-bit word {byte1, byte2}; green keeps G[5:1]
   localparam int RED_MSB = 15;
   localparam int RED_LSB = 11;
   localparam int GRN_MSB = 10;
   localparam int GRN_LSB = 6;
   localparam int BLU_MSB = 4;
   localparam int BLU_LSB = 0;

endpackage
`default_nettype wire

// File: rtl/cam_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cam_sync                                                                   |
// | Two-flop synchroniser plus one delay flop; level and edge strobes.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module cam_sync #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] i_async,
   output logic [WIDTH-1:0] o_level,
   output logic [WIDTH-1:0] o_rise,
   output logic [WIDTH-1:0] o_fall
);

   logic [WIDTH-1:0] r_s1;
   logic [WIDTH-1:0] r_s2;
   logic [WIDTH-1:0] r_s3;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1 <= '0;
         r_s2 <= '0;
         r_s3 <= '0;
      end else begin
         r_s1 <= i_async;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   assign o_level = r_s2;
   assign o_rise  = r_s2 & ~r_s3;
   assign o_fall  = ~r_s2 & r_s3;

endmodule
`default_nettype wire

// File: rtl/cam_capture.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cam_capture                                                                |
// | OV7670 byte-pair capture into 5/5/5 pixels with linear index and overrun.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module cam_capture
   import cam_pkg::*;
#(
   parameter int HRES  = H_ACTIVE,
   parameter int VRES  = V_ACTIVE,
   parameter int IDX_W = 19
) (
   input  logic             CLK,
   input  logic             RESETn,
   input  logic             en,
   input  logic             PCLK,
   input  logic             VSYNC,
   input  logic             HREF,
   input  logic [7:0]       D,
   output logic [4:0]       red,
   output logic [4:0]       green,
   output logic [4:0]       blue,
   output logic [IDX_W-1:0] index,
   output logic             valid,
   output logic             frame_done,
   output logic             overrun
);

   localparam int               FRAME_PIX = HRES * VRES;
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FRAME_PIX - 1);

   logic             r_rst_meta;
   logic             r_rst_n;
   logic             w_pclk_rise;
   logic             w_vsync_rise;
   logic             w_vsync_fall;
   logic             w_href;
   logic [7:0]       w_d;
   logic [15:0]      w_pixel;
   logic             w_pix_done;
   cam_state_t       r_state;
   logic             r_phase;
   logic [7:0]       r_byte1;
   logic [IDX_W-1:0] r_count;
   logic             r_full;
   logic             r_done_pend;

   // Assert asynchronously, release on a clock edge
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         r_rst_meta <= 1'b0;
         r_rst_n    <= 1'b0;
      end else begin
         r_rst_meta <= 1'b1;
         r_rst_n    <= r_rst_meta;
      end
   end

   logic       w_pclk_lvl, w_pclk_fall;
   logic       w_vsync_lvl;
   logic       w_href_rise, w_href_fall;
   logic [7:0] w_d_rise, w_d_fall;

   cam_sync #(.WIDTH(1)) u_pclk_sync (
      .clk(CLK), .rst_n(r_rst_n), .i_async(PCLK),
      .o_level(w_pclk_lvl), .o_rise(w_pclk_rise), .o_fall(w_pclk_fall)
   );

   cam_sync #(.WIDTH(1)) u_vsync_sync (
      .clk(CLK), .rst_n(r_rst_n), .i_async(VSYNC),
      .o_level(w_vsync_lvl), .o_rise(w_vsync_rise), .o_fall(w_vsync_fall)
   );

   cam_sync #(.WIDTH(1)) u_href_sync (
      .clk(CLK), .rst_n(r_rst_n), .i_async(HREF),
      .o_level(w_href), .o_rise(w_href_rise), .o_fall(w_href_fall)
   );

   cam_sync #(.WIDTH(8)) u_data_sync (
      .clk(CLK), .rst_n(r_rst_n), .i_async(D),
      .o_level(w_d), .o_rise(w_d_rise), .o_fall(w_d_fall)
   );

   logic w_unused_sync;
   assign w_unused_sync = ^{w_pclk_lvl, w_pclk_fall, w_vsync_lvl, w_href_rise,
                            w_href_fall, w_d_rise, w_d_fall, w_pixel[5]};

   assign w_pixel    = {r_byte1, w_d};
   assign w_pix_done = (r_state == ACTIVE) && w_pclk_rise && w_href && r_phase;

   always_ff @(posedge CLK or negedge r_rst_n) begin
      if (!r_rst_n) begin
         r_state     <= IDLE;
         r_phase     <= 1'b0;
         r_byte1     <= '0;
         r_count     <= '0;
         r_full      <= 1'b0;
         r_done_pend <= 1'b0;
         red         <= '0;
         green       <= '0;
         blue        <= '0;
         index       <= '0;
         valid       <= 1'b0;
         frame_done  <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         valid      <= 1'b0;
         frame_done <= 1'b0;
         if (!en) begin
            // Abandon the frame: partial pixel and pending frame_done are dropped
            r_state     <= IDLE;
            r_phase     <= 1'b0;
            r_done_pend <= 1'b0;
         end else begin
            frame_done  <= r_done_pend;
            r_done_pend <= 1'b0;
            case (r_state)
               IDLE: r_state <= WAIT_FRAME;
               WAIT_FRAME: begin
                  if (w_vsync_fall) begin
                     r_state <= ACTIVE;
                     r_phase <= 1'b0;
                     r_count <= '0;
                     r_full  <= 1'b0;
                     index   <= '0;
                     overrun <= 1'b0;
                  end
               end
               ACTIVE: begin
                  if (w_pclk_rise) begin
                     if (!w_href) begin
                        r_phase <= 1'b0;
                     end else if (!r_phase) begin
                        r_byte1 <= w_d;
                        r_phase <= 1'b1;
                     end else begin
                        r_phase <= 1'b0;
                        if (r_full) begin
                           overrun <= 1'b1;
                        end else begin
                           valid <= 1'b1;
                           red   <= w_pixel[RED_MSB:RED_LSB];
                           green <= w_pixel[GRN_MSB:GRN_LSB];
                           blue  <= w_pixel[BLU_MSB:BLU_LSB];
                           index <= r_count;
                           if (r_count == LAST_IDX) r_full  <= 1'b1;
                           else                     r_count <= r_count + 1'b1;
                        end
                     end
                  end
                  if (w_vsync_rise) begin
                     r_state <= WAIT_FRAME;
                     // A pixel strobing in this cycle goes first; frame_done follows
                     if (w_pix_done && !r_full) r_done_pend <= 1'b1;
                     else                       frame_done  <= 1'b1;
                  end
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cam_capture.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_cam_capture                                                             |
// | Directed pin-level stimulus on a 4x3 frame with hand-computed pixels.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_cam_capture;

   localparam int HRES  = 4;
   localparam int VRES  = 3;
   localparam int IDX_W = 4;

   logic             CLK = 1'b0;
   logic             RESETn = 1'b0;
   logic             en = 1'b1;
   logic             PCLK = 1'b0;
   logic             VSYNC = 1'b1;
   logic             HREF = 1'b0;
   logic [7:0]       D = 8'h00;
   logic [4:0]       red, green, blue;
   logic [IDX_W-1:0] index;
   logic             valid, frame_done, overrun;

   cam_capture #(.HRES(HRES), .VRES(VRES), .IDX_W(IDX_W)) dut (
      .CLK(CLK), .RESETn(RESETn), .en(en), .PCLK(PCLK), .VSYNC(VSYNC),
      .HREF(HREF), .D(D), .red(red), .green(green), .blue(blue),
      .index(index), .valid(valid), .frame_done(frame_done), .overrun(overrun)
   );

   always #5 CLK = ~CLK;

   int tests = 0;
   int fails = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Strobe monitor, sampled on the falling clock edge
   int         cyc = 0;
   int         frame_no = 0;
   int         mon_frame_seen = 0;
   int         mon_exp_idx = 0;
   int         mon_valids = 0;
   int         mon_dones = 0;
   int         mon_seq_err = 0;
   int         last_valid_cyc = 0;
   int         last_done_cyc = 0;
   logic [4:0] last_r = '0, last_g = '0, last_b = '0;
   logic [3:0] last_idx = '0;

   always @(posedge CLK) cyc <= cyc + 1;

   always @(negedge CLK) begin
      if (valid === 1'b1) begin
         if (frame_no != mon_frame_seen) begin
            mon_exp_idx    = 0;
            mon_frame_seen = frame_no;
         end
         if (index !== 4'(mon_exp_idx)) mon_seq_err++;
         mon_exp_idx++;
         mon_valids++;
         last_valid_cyc = cyc;
         last_r   = red;
         last_g   = green;
         last_b   = blue;
         last_idx = index;
      end
      if (frame_done === 1'b1) begin
         mon_dones++;
         last_done_cyc = cyc;
      end
   end

   // One PCLK period of 4 CLK: data changes with the falling PCLK edge
   task automatic pclk_cycle(input logic [7:0] d, input logic h, input logic vs_at_rise);
      @(negedge CLK);
      PCLK = 1'b0;
      D    = d;
      HREF = h;
      repeat (2) @(negedge CLK);
      PCLK = 1'b1;
      if (vs_at_rise) VSYNC = 1'b1;
      @(negedge CLK);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) pclk_cycle(8'h00, 1'b0, 1'b0);
   endtask

   task automatic send_line(input int n_bytes, input logic [7:0] b1, input logic [7:0] b2);
      for (int i = 0; i < n_bytes; i++) pclk_cycle((i % 2) ? b2 : b1, 1'b1, 1'b0);
      idle(2);
   endtask

   task automatic frame_start();
      frame_no++;
      idle(2);
      @(negedge CLK);
      VSYNC = 1'b0;
      idle(3);
   endtask

   task automatic frame_end();
      idle(1);
      @(negedge CLK);
      VSYNC = 1'b1;
      repeat (8) @(negedge CLK);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   int v0, d0, e0;

   initial begin
      // Reset state
      #23;
      check("rst_valid", valid, 0);
      check("rst_done", frame_done, 0);
      check("rst_overrun", overrun, 0);
      check("rst_index", index, 0);
      check("rst_red", red, 0);
      check("rst_green", green, 0);
      check("rst_blue", blue, 0);
      @(negedge CLK);
      RESETn = 1'b1;
      repeat (5) @(negedge CLK);

      // Full frame of 0xF8,0x1F pixels
      v0 = mon_valids; d0 = mon_dones; e0 = mon_seq_err;
      frame_start();
      for (int l = 0; l < VRES; l++) send_line(2 * HRES, 8'hF8, 8'h1F);
      frame_end();
      check("full_valids", mon_valids - v0, 12);
      check("full_red", last_r, 31);
      check("full_green", last_g, 0);
      check("full_blue", last_b, 31);
      check("full_last_idx", last_idx, 11);
      check("full_seq", mon_seq_err - e0, 0);
      check("full_dones", mon_dones - d0, 1);
      check("full_overrun", overrun, 0);

      // Green-only pixel, odd trailing byte, then a fresh line at phase 0
      v0 = mon_valids; d0 = mon_dones;
      frame_start();
      pclk_cycle(8'h07, 1'b1, 1'b0);
      pclk_cycle(8'hE0, 1'b1, 1'b0);
      pclk_cycle(8'hAA, 1'b1, 1'b0);
      idle(2);
      check("g_valids", mon_valids - v0, 1);
      check("g_red", last_r, 0);
      check("g_green", last_g, 31);
      check("g_blue", last_b, 0);
      send_line(2, 8'h12, 8'h34);
      check("odd_valids", mon_valids - v0, 2);
      check("odd_red", last_r, 2);
      check("odd_green", last_g, 8);
      check("odd_blue", last_b, 20);
      check("odd_idx", last_idx, 1);
      frame_end();
      check("short_dones", mon_dones - d0, 1);

      // One pixel too many
      v0 = mon_valids; d0 = mon_dones;
      frame_start();
      for (int l = 0; l < VRES; l++) send_line(2 * HRES, 8'hF8, 8'h1F);
      check("ovr_armed_only", overrun, 0);
      send_line(2, 8'h07, 8'hE0);
      check("ovr_valids", mon_valids - v0, 12);
      check("ovr_last_idx", last_idx, 11);
      check("ovr_red_held", last_r, 31);
      check("ovr_flag", overrun, 1);
      frame_end();
      check("ovr_dones", mon_dones - d0, 1);
      check("ovr_sticky", overrun, 1);
      frame_start();
      check("ovr_clear", overrun, 0);
      check("ovr_idx_clear", index, 0);
      send_line(2 * HRES, 8'hF8, 8'h1F);
      frame_end();

      // en dropped mid-line
      v0 = mon_valids; d0 = mon_dones;
      frame_start();
      for (int i = 0; i < 4; i++) pclk_cycle((i % 2) ? 8'h1F : 8'hF8, 1'b1, 1'b0);
      pclk_cycle(8'hF8, 1'b1, 1'b0);
      @(negedge CLK);
      en = 1'b0;
      for (int i = 0; i < 5; i++) pclk_cycle((i % 2) ? 8'hF8 : 8'h1F, 1'b1, 1'b0);
      idle(2);
      check("en_off_valids", mon_valids - v0, 2);
      @(negedge CLK);
      en = 1'b1;
      idle(2);
      send_line(4, 8'hF8, 8'h1F);
      frame_end();
      check("en_wait_valids", mon_valids - v0, 2);
      check("en_no_done", mon_dones - d0, 0);
      v0 = mon_valids; d0 = mon_dones;
      frame_start();
      send_line(2 * HRES, 8'h07, 8'hE0);
      frame_end();
      check("en_resume_valids", mon_valids - v0, 4);
      check("en_resume_idx", last_idx, 3);
      check("en_resume_done", mon_dones - d0, 1);

      // Asynchronous reset mid-frame
      v0 = mon_valids; d0 = mon_dones; e0 = mon_seq_err;
      frame_start();
      send_line(6, 8'hF8, 8'h1F);
      check("ar_pre_valids", mon_valids - v0, 3);
      #2;
      RESETn = 1'b0;
      #1;
      check("ar_red", red, 0);
      check("ar_blue", blue, 0);
      check("ar_index", index, 0);
      @(negedge CLK);
      RESETn = 1'b1;
      repeat (4) @(negedge CLK);
      send_line(2 * HRES, 8'hF8, 8'h1F);
      frame_end();
      check("ar_wait_valids", mon_valids - v0, 3);
      check("ar_no_done", mon_dones - d0, 0);
      v0 = mon_valids;
      frame_start();
      send_line(2 * HRES, 8'hF8, 8'h1F);
      frame_end();
      check("ar_after_valids", mon_valids - v0, 4);
      check("ar_seq", mon_seq_err - e0, 0);

      // VSYNC rise coincident with final byte
      v0 = mon_valids; d0 = mon_dones;
      frame_start();
      pclk_cycle(8'hF8, 1'b1, 1'b0);
      pclk_cycle(8'h1F, 1'b1, 1'b0);
      pclk_cycle(8'h07, 1'b1, 1'b0);
      pclk_cycle(8'hE0, 1'b1, 1'b1);
      idle(3);
      check("co_valids", mon_valids - v0, 2);
      check("co_dones", mon_dones - d0, 1);
      check("co_order", last_done_cyc - last_valid_cyc, 1);
      check("co_green", last_g, 31);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
